// File: rtl/ulight_pio_pkg.sv
// Shared definitions for the uLight Avalon-MM PIO blocks.
//
// Contents:
//   AVALON_DW       fixed Avalon-MM data width
//   ADDR_*          word addresses of the 4-word PIO register window
//   EDGE_*          encodings for the EDGE_TYPE parameter of input PIOs
package ulight_pio_pkg;

   localparam int unsigned AVALON_DW = 32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/ulight_sync_bus.sv
// Multi-bit synchronizer: each line of d_i passes through STAGES flops before
// appearing on q_o. Lines are synchronized independently, so a multi-bit change
// may be seen on q_o over more than one cycle.
//
// Ports:
//   clk_i   clock of the destination domain
//   clr_ni  synchronous active-low clear of every stage
//   d_i     asynchronous input lines
//   q_o     synchronized lines (output of the last stage)
module ulight_sync_bus #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         stage_q <= '0;
      end else begin
         // Stage 0 samples the pad; higher indices are further down the chain.
         stage_q <= {stage_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ulight_fifo_status_in.sv
// Avalon-MM input PIO for the uLight FIFO / SpaceWire link status lines.
// Synchronizes the lines into clk, captures the selected edge per line into a
// sticky write-1-to-clear register, and raises a maskable level interrupt.
//
// Register window (word addresses, bits above WIDTH-1 read 0):
//   0 DATA         synchronized input lines (read-only)
//   1 RSVD         reads 0
//   2 IRQMASK      per-line interrupt enable (read/write)
//   3 EDGECAPTURE  sticky edge flags (read, write-1-to-clear)
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous status lines
//   readdata    registered read data, 1-cycle latency, address-driven only
//   irq         level interrupt, high while any unmasked capture bit is set
module ulight_fifo_status_in
   import ulight_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned EDGE_TYPE   = EDGE_RISE,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [AVALON_DW-1:0] writedata,
   input  logic [WIDTH-1:0]     in_port,
   output logic [AVALON_DW-1:0] readdata,
   output logic                 irq
);

   // The arm counter must outlast the reset-zeroed synchronizer plus prev.
   localparam int unsigned ArmMax = SYNC_STAGES + 1;
   localparam int unsigned ArmW   = $clog2(ArmMax + 1);

   logic [WIDTH-1:0]     sync_in;
   logic [WIDTH-1:0]     prev_q;
   logic [WIDTH-1:0]     irqmask_q, irqmask_d;
   logic [WIDTH-1:0]     edgecap_q, edgecap_d;
   logic [AVALON_DW-1:0] readdata_q, readdata_d;
   logic                 irq_q, irq_d;
   logic [ArmW-1:0]      arm_q, arm_d;

   logic                 armed;
   logic                 wr_en;
   logic [WIDTH-1:0]     wdata;
   logic [WIDTH-1:0]     clr;
   logic [WIDTH-1:0]     rise, fall, edge_det;

   // Upper writedata bits are intentionally ignored when WIDTH < 32.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   ulight_sync_bus #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk),
      .clr_ni (reset_n),
      .d_i    (in_port),
      .q_o    (sync_in)
   );

   //---------------------------------------------------------------------------
   // Edge detection, gated until the pipeline holds real samples
   //---------------------------------------------------------------------------
   assign armed = (arm_q == ArmW'(ArmMax));
   assign arm_d = armed ? arm_q : arm_q + ArmW'(1);

   assign rise = sync_in & ~prev_q;
   assign fall = ~sync_in & prev_q;

   always_comb begin
      edge_det = '0;
      if (armed) begin
         case (EDGE_TYPE)
            EDGE_RISE: edge_det = rise;
            EDGE_FALL: edge_det = fall;
            default:   edge_det = rise | fall;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Register writes
   //---------------------------------------------------------------------------
   assign wr_en = chipselect & ~write_n;
   assign wdata = writedata[WIDTH-1:0];
   assign clr   = (wr_en && (address == ADDR_EDGECAP)) ? wdata : '0;

   assign irqmask_d = (wr_en && (address == ADDR_IRQMASK)) ? wdata : irqmask_q;

   // Set dominates clear so an edge coincident with a W1C is never lost.
   assign edgecap_d = (edgecap_q & ~clr) | edge_det;

   assign irq_d = |(edgecap_d & irqmask_d);

   //---------------------------------------------------------------------------
   // Read mux: sampled every cycle from pre-edge register state
   //---------------------------------------------------------------------------
   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_in;
         ADDR_RSVD:    readdata_d            = '0;
         ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      endcase
   end

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
         arm_q      <= '0;
      end else begin
         prev_q     <= sync_in;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
         arm_q      <= arm_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
